// File: rtl/semaforo_pkg.sv
// Shared constants and channel indices for the intersection input-conditioning stage.
// Channel enum indexes the 5-bit raw / synchronised / debounced vectors.
package semaforo_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int E_HOLD_DEF     = 8;
  localparam int NCH            = 5;

  typedef enum logic [2:0] {
    CH_TAV = 3'd0,
    CH_TBV = 3'd1,
    CH_E   = 3'd2,
    CH_P   = 3'd3,
    CH_B   = 3'd4
  } chan_e;

endpackage

// File: rtl/semaforo_debounce.sv
// One channel: 2-flop synchroniser, then a stable level that toggles only after DEB_CYCLES
// consecutive mismatching samples. Exposes the level's next value; no backpressure.
module semaforo_debounce
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level_nxt
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Any match restarts the count, so a short glitch never accumulates across pulses.
  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    if (sync[1] != level) begin
      if (cnt == CW'(DEB_CYCLES - 1)) begin
        level_nxt = sync[1];
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], din};
      level <= level_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/semaforo_entradas.sv
// Debounced loop/emergency levels plus sticky P/B requests cleared by the served light's rising edge;
// levels lag raw by DEB_CYCLES+2 edges, no backpressure. SEMAFORO_EMERG_HOLD_EN stretches E by E_HOLD.
module semaforo_entradas
  import semaforo_pkg::*;
#(
`ifdef SEMAFORO_EMERG_HOLD_EN
  parameter int E_HOLD     = E_HOLD_DEF,
`endif
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tav_raw,
  input  logic tbv_raw,
  input  logic e_raw,
  input  logic p_btn,
  input  logic b_btn,
  input  logic av_r,
  input  logic bici_g,
  output logic TAv,
  output logic TBv,
  output logic E,
  output logic P,
  output logic B
);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] deb_nxt;
  logic [NCH-1:0] deb;
  logic           av_r_q;
  logic           bici_g_q;
  logic           p_lat;
  logic           b_lat;
  logic           p_set;
  logic           p_clr;
  logic           b_set;
  logic           b_clr;

  assign raw[CH_TAV] = tav_raw;
  assign raw[CH_TBV] = tbv_raw;
  assign raw[CH_E]   = e_raw;
  assign raw[CH_P]   = p_btn;
  assign raw[CH_B]   = b_btn;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    semaforo_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .din      (raw[i]),
      .level_nxt(deb_nxt[i])
    );
  end

  // Set on the very edge the debounced press lands; a serve on that same edge drops it.
  assign p_set = deb_nxt[CH_P] & ~deb[CH_P];
  assign b_set = deb_nxt[CH_B] & ~deb[CH_B];
  assign p_clr = av_r & ~av_r_q;
  assign b_clr = bici_g & ~bici_g_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb      <= '0;
      av_r_q   <= 1'b0;
      bici_g_q <= 1'b0;
      p_lat    <= 1'b0;
      b_lat    <= 1'b0;
    end else begin
      deb      <= deb_nxt;
      av_r_q   <= av_r;
      bici_g_q <= bici_g;
      if (p_clr) begin
        p_lat <= 1'b0;
      end else if (p_set) begin
        p_lat <= 1'b1;
      end
      if (b_clr) begin
        b_lat <= 1'b0;
      end else if (b_set) begin
        b_lat <= 1'b1;
      end
    end
  end

  assign TAv = deb[CH_TAV];
  assign TBv = deb[CH_TBV];
  assign P   = p_lat;
  assign B   = b_lat;

`ifdef SEMAFORO_EMERG_HOLD_EN
  logic [7:0] e_hold;

  // Loaded on each debounced fall; a re-rise mid-hold just lets the countdown run under the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_hold <= '0;
    end else if (deb[CH_E] & ~deb_nxt[CH_E]) begin
      e_hold <= 8'(E_HOLD);
    end else if (e_hold != 8'd0) begin
      e_hold <= e_hold - 8'd1;
    end
  end

  assign E = deb[CH_E] | (e_hold != 8'd0);
`else
  assign E = deb[CH_E];
`endif

endmodule
